// File: rtl/multi_chrono.sv
// NUM_CH independent H:M:S counters sharing one command port and a 1 Hz tick.
// Each channel counts up with wrap or down to zero; LAP snapshots the live value.

module multi_chrono_ch #(
    parameter int H_MAX = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        sel,
    input  logic [2:0]  op,
    input  logic [17:0] data,
    output logic [17:0] count,
    output logic [17:0] lap,
    output logic        running,
    output logic        done,
    output logic        wrap
);
    localparam logic [2:0] OP_START = 3'd1, OP_STOP = 3'd2, OP_CLEAR = 3'd3,
                           OP_LOAD  = 3'd4, OP_LAP  = 3'd5, OP_MODE  = 3'd6;

    typedef struct packed {
        logic [5:0] hr;
        logic [5:0] mn;
        logic [5:0] sec;
    } hms_t;

    hms_t cnt_q, lap_q, nxt_up, nxt_dn;
    logic run_q, down_q, done_q, wrap_q, up_wrap, hold, adv, at_zero;

    assign count   = cnt_q;
    assign lap     = lap_q;
    assign running = run_q;
    assign done    = done_q;
    assign wrap    = wrap_q;
    assign at_zero = (cnt_q == '0);

    // State-changing commands win over a same-cycle tick; LAP/NOP let it through.
    assign hold = sel && (op inside {OP_START, OP_STOP, OP_CLEAR, OP_LOAD, OP_MODE});
    assign adv  = tick && run_q && !hold;

    always_comb begin
        nxt_up  = cnt_q;
        up_wrap = 1'b0;
        if (cnt_q.sec != 6'd59) begin
            nxt_up.sec = cnt_q.sec + 6'd1;
        end else begin
            nxt_up.sec = '0;
            if (cnt_q.mn != 6'd59) begin
                nxt_up.mn = cnt_q.mn + 6'd1;
            end else begin
                nxt_up.mn = '0;
                if (cnt_q.hr == 6'(H_MAX)) begin
                    nxt_up.hr = '0;
                    up_wrap   = 1'b1;
                end else begin
                    nxt_up.hr = cnt_q.hr + 6'd1;
                end
            end
        end
    end

    // Only used when the value is nonzero, so hr is nonzero whenever both borrow.
    always_comb begin
        nxt_dn = cnt_q;
        if (cnt_q.sec != '0) begin
            nxt_dn.sec = cnt_q.sec - 6'd1;
        end else begin
            nxt_dn.sec = 6'd59;
            if (cnt_q.mn != '0) begin
                nxt_dn.mn = cnt_q.mn - 6'd1;
            end else begin
                nxt_dn.mn = 6'd59;
                nxt_dn.hr = cnt_q.hr - 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            lap_q  <= '0;
            run_q  <= 1'b0;
            down_q <= 1'b0;
            done_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            if (adv) begin
                if (!down_q) begin
                    cnt_q  <= nxt_up;
                    wrap_q <= up_wrap;
                end else if (at_zero) begin
                    run_q <= 1'b0;
                end else begin
                    cnt_q <= nxt_dn;
                    if (nxt_dn == '0) begin
                        done_q <= 1'b1;
                        run_q  <= 1'b0;
                    end
                end
            end
            if (sel) begin
                case (op)
                    OP_START: run_q  <= 1'b1;
                    OP_STOP:  run_q  <= 1'b0;
                    OP_CLEAR: begin cnt_q <= '0; lap_q <= '0; end
                    OP_LOAD:  cnt_q  <= data;
                    OP_LAP:   lap_q  <= cnt_q;
                    OP_MODE:  down_q <= data[0];
                    default:  ;
                endcase
            end
        end
    end
endmodule

module multi_chrono #(
    parameter int NUM_CH = 2,
    parameter int H_MAX  = 23,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 cmd_valid,
    input  logic [CH_W-1:0]      cmd_ch,
    input  logic [2:0]           cmd_op,
    input  logic [17:0]          cmd_data,
    output logic                 cmd_ack,
    output logic                 cmd_err,
    output logic [NUM_CH*18-1:0] count,
    output logic [NUM_CH*18-1:0] lap,
    output logic [NUM_CH-1:0]    running,
    output logic [NUM_CH-1:0]    done,
    output logic [NUM_CH-1:0]    wrap
);
    logic              ld_bad, ch_bad, rej;
    logic [NUM_CH-1:0] sel;

    assign ld_bad = (cmd_data[5:0] > 6'd59) || (cmd_data[11:6] > 6'd59) ||
                    (cmd_data[17:12] > 6'(H_MAX));
    assign ch_bad = ({1'b0, cmd_ch} >= (CH_W+1)'(NUM_CH));
    assign rej    = (cmd_op == 3'd7) || ch_bad || ((cmd_op == 3'd4) && ld_bad);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_ack <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            cmd_ack <= cmd_valid;
            cmd_err <= cmd_valid && rej;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign sel[i] = cmd_valid && !rej && (cmd_ch == CH_W'(i));

        multi_chrono_ch #(.H_MAX(H_MAX)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .sel     (sel[i]),
            .op      (cmd_op),
            .data    (cmd_data),
            .count   (count[18*i +: 18]),
            .lap     (lap[18*i +: 18]),
            .running (running[i]),
            .done    (done[i]),
            .wrap    (wrap[i])
        );
    end
endmodule

// File: tb/tb_multi_chrono.sv
// Random and directed stimulus against a seconds-since-midnight model of every channel.
module tb_multi_chrono;
    localparam int NUM_CH = 3;
    localparam int H_MAX  = 23;
    localparam int CH_W   = 2;
    localparam int DAY    = (H_MAX + 1) * 3600;

    logic                 clk = 1'b0, rst = 1'b1, tick = 1'b0, cmd_valid = 1'b0;
    logic [CH_W-1:0]      cmd_ch = '0;
    logic [2:0]           cmd_op = '0;
    logic [17:0]          cmd_data = '0;
    logic                 cmd_ack, cmd_err;
    logic [NUM_CH*18-1:0] count, lap;
    logic [NUM_CH-1:0]    running, done, wrap;

    multi_chrono #(.NUM_CH(NUM_CH), .H_MAX(H_MAX)) dut (
        .clk(clk), .rst(rst), .tick(tick), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_ack(cmd_ack), .cmd_err(cmd_err),
        .count(count), .lap(lap), .running(running), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int m_t[NUM_CH], m_lap[NUM_CH];
    bit m_run[NUM_CH], m_dn[NUM_CH];
    logic [NUM_CH-1:0] e_done, e_wrap;
    logic e_ack, e_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] hms(input int s);
        return {6'(s / 3600), 6'((s / 60) % 60), 6'(s % 60)};
    endfunction

    function automatic int secs(input logic [17:0] v);
        return int'(v[17:12]) * 3600 + int'(v[11:6]) * 60 + int'(v[5:0]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_t[i] = 0; m_lap[i] = 0; m_run[i] = 0; m_dn[i] = 0;
        end
        e_done = '0; e_wrap = '0; e_ack = 0; e_err = 0;
    endtask

    task automatic model_step(input bit tk, input bit v, input int ch, input int op,
                              input logic [17:0] d);
        bit rej, hold;
        e_ack = v; e_done = '0; e_wrap = '0;
        rej = v && (op == 7 || ch >= NUM_CH ||
                    (op == 4 && (d[5:0] > 59 || d[11:6] > 59 || d[17:12] > H_MAX)));
        e_err = rej;
        for (int i = 0; i < NUM_CH; i++) begin
            hold = 0;
            if (v && !rej && ch == i) begin
                case (op)
                    1: begin m_run[i] = 1; hold = 1; end
                    2: begin m_run[i] = 0; hold = 1; end
                    3: begin m_t[i] = 0; m_lap[i] = 0; hold = 1; end
                    4: begin m_t[i] = secs(d); hold = 1; end
                    5: m_lap[i] = m_t[i];
                    6: begin m_dn[i] = d[0]; hold = 1; end
                    default: ;
                endcase
            end
            if (tk && !hold && m_run[i]) begin
                if (!m_dn[i]) begin
                    m_t[i] = (m_t[i] + 1) % DAY;
                    if (m_t[i] == 0) e_wrap[i] = 1;
                end else if (m_t[i] == 0) begin
                    m_run[i] = 0;
                end else begin
                    m_t[i]--;
                    if (m_t[i] == 0) begin e_done[i] = 1; m_run[i] = 0; end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [NUM_CH*18-1:0] ec, el;
        logic [NUM_CH-1:0] er;
        for (int i = 0; i < NUM_CH; i++) begin
            ec[18*i +: 18] = hms(m_t[i]);
            el[18*i +: 18] = hms(m_lap[i]);
            er[i] = m_run[i];
        end
        chk({tag, "/count"}, 64'(count), 64'(ec));
        chk({tag, "/lap"}, 64'(lap), 64'(el));
        chk({tag, "/running"}, 64'(running), 64'(er));
        chk({tag, "/done"}, 64'(done), 64'(e_done));
        chk({tag, "/wrap"}, 64'(wrap), 64'(e_wrap));
        chk({tag, "/ack"}, 64'(cmd_ack), 64'(e_ack));
        chk({tag, "/err"}, 64'(cmd_err), 64'(e_err));
    endtask

    task automatic step(input bit tk, input bit v, input int ch, input int op,
                        input logic [17:0] d);
        tick = tk; cmd_valid = v; cmd_ch = CH_W'(ch); cmd_op = 3'(op); cmd_data = d;
        @(posedge clk);
        #1;
        model_step(tk, v, ch, op, d);
        check_all("step");
        tick = 0; cmd_valid = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int op, ch;
        logic [17:0] d;
        #1 rst = 0;
        #11;
        model_reset();
        check_all("reset");
        @(negedge clk) rst = 1;

        // up count 1:01:01
        step(0, 1, 0, 6, 18'd0);
        step(0, 1, 0, 1, 18'd0);
        repeat (3661) step(1, 0, 0, 0, 18'd0);
        chk("t1_hms", 64'(count[17:0]), 64'({6'd1, 6'd1, 6'd1}));
        chk("t1_run", 64'(running[0]), 64'd1);

        // wrap at end of day
        step(0, 1, 0, 4, {6'd23, 6'd59, 6'd58});
        step(0, 1, 0, 1, 18'd0);
        step(1, 0, 0, 0, 18'd0);
        chk("t2_nowrap", 64'(wrap[0]), 64'd0);
        step(1, 0, 0, 0, 18'd0);
        chk("t2_wrap", 64'(wrap[0]), 64'd1);
        chk("t2_zero", 64'(count[17:0]), 64'd0);
        step(1, 0, 0, 0, 18'd0);
        chk("t2_cont", 64'(count[17:0]), 64'd1);

        // countdown on ch1
        step(0, 1, 1, 6, 18'd1);
        step(0, 1, 1, 4, {6'd0, 6'd1, 6'd0});
        step(0, 1, 1, 1, 18'd0);
        repeat (60) step(1, 0, 0, 0, 18'd0);
        chk("t3_done", 64'(done[1]), 64'd1);
        chk("t3_run", 64'(running[1]), 64'd0);
        step(1, 0, 0, 0, 18'd0);
        chk("t3_nodone", 64'(done[1]), 64'd0);
        chk("t3_hold", 64'(count[35:18]), 64'd0);

        // LAP and STOP colliding with tick
        step(0, 1, 0, 4, {6'd0, 6'd0, 6'd5});
        step(1, 1, 0, 5, 18'd0);
        chk("t4_lap", 64'(lap[17:0]), 64'd5);
        chk("t4_cnt", 64'(count[17:0]), 64'd6);
        step(1, 1, 0, 2, 18'd0);
        chk("t4_stop", 64'(count[17:0]), 64'd6);

        // rejected commands
        step(1, 1, 0, 4, {6'd0, 6'd60, 6'd0});
        chk("t5_badload", 64'(cmd_err), 64'd1);
        step(0, 1, 3, 1, 18'd0);
        chk("t5_badch", 64'(cmd_err), 64'd1);
        step(0, 1, 0, 7, 18'd0);
        chk("t5_rsvd", 64'(cmd_err), 64'd1);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            op = $urandom_range(0, 7);
            ch = $urandom_range(0, 3);
            case ($urandom_range(0, 3))
                0: d = 18'($urandom);
                1: d = {6'(H_MAX), 6'd59, 6'($urandom_range(55, 59))};
                2: d = {6'd0, 6'd0, 6'($urandom_range(0, 4))};
                default: d = {6'($urandom_range(0, H_MAX)), 6'($urandom_range(0, 59)),
                              6'($urandom_range(0, 59))};
            endcase
            if (op == 6) d = {17'd0, 1'($urandom)};
            step(bit'($urandom_range(0, 1)), $urandom_range(0, 2) != 0, ch, op, d);
        end

        // asynchronous reset mid-count
        step(0, 1, 0, 3, 18'd0);
        step(0, 1, 0, 6, 18'd0);
        step(0, 1, 0, 1, 18'd0);
        repeat (137) step(1, 0, 0, 0, 18'd0);
        chk("t6_pre", 64'(count[17:0]), 64'({6'd0, 6'd2, 6'd17}));
        #2 rst = 0;
        #1;
        model_reset();
        check_all("t6_async");
        tick = 1;
        @(posedge clk);
        #1;
        check_all("t6_held");
        tick = 0;
        @(negedge clk) rst = 1;
        step(0, 1, 0, 1, 18'd0);
        step(1, 0, 0, 0, 18'd0);
        chk("t6_after", 64'(count[17:0]), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
